// File: rtl/trace_pkg.sv
// Shared types and constants for the pipeline trace emitter: shadow-slot and
// retirement-record layouts plus cycle/stall counter widths.
package trace_pkg;

    localparam int unsigned CYC_W    = 32;
    localparam int unsigned STALL_W  = 3;
    localparam int unsigned DROP_W   = 16;
    // PC/instr fields are stored at this width; the top zero-extends W-bit words.
    localparam int unsigned PC_W_MAX = 32;

    localparam logic [STALL_W-1:0] STALL_CNT_MAX = 3'd7;
    localparam logic [DROP_W-1:0]  DROP_CNT_MAX  = 16'hFFFF;

    typedef logic [PC_W_MAX-1:0] word_t;
    typedef logic [CYC_W-1:0]    cyc_t;

    typedef struct packed {
        logic                valid;
        word_t               pc;
        word_t               instr;
        cyc_t                fetch_cyc;
        logic [STALL_W-1:0]  stall_cnt;
    } slot_t;

    typedef struct packed {
        word_t               pc;
        word_t               instr;
        cyc_t                fetch_cyc;
        cyc_t                retire_cyc;
        logic [STALL_W-1:0]  stall_cnt;
    } rec_t;

    function automatic logic [STALL_W-1:0] sat_inc_stall(input logic [STALL_W-1:0] cnt);
        return (cnt == STALL_CNT_MAX) ? cnt : cnt + 1'b1;
    endfunction

endpackage

// File: rtl/pipeline_trace_emitter_if.sv
// Pipeline-side inputs and trace-record outputs of the emitter, bundled.
interface pipeline_trace_emitter_if #(
    parameter int unsigned W = 16
);
    import trace_pkg::*;

    logic                if_valid;
    logic [W-1:0]        if_pc;
    logic [W-1:0]        if_instr;
    logic                stall;
    logic                flush;
    logic                out_ready;
    logic                out_valid;
    logic [W-1:0]        out_pc;
    logic [W-1:0]        out_instr;
    logic [CYC_W-1:0]    out_fetch_cyc;
    logic [CYC_W-1:0]    out_retire_cyc;
    logic [STALL_W-1:0]  out_stall_cnt;
    logic [DROP_W-1:0]   drop_cnt;

    modport master (
        output if_valid, if_pc, if_instr, stall, flush, out_ready,
        input  out_valid, out_pc, out_instr, out_fetch_cyc, out_retire_cyc,
               out_stall_cnt, drop_cnt
    );

    modport slave (
        input  if_valid, if_pc, if_instr, stall, flush, out_ready,
        output out_valid, out_pc, out_instr, out_fetch_cyc, out_retire_cyc,
               out_stall_cnt, drop_cnt
    );

endinterface

// File: rtl/trace_fifo.sv
// Retirement-record FIFO; pointers carry one extra wrap bit to tell full from empty.
module trace_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter type         rec_t = logic
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  rec_t push_data,
    input  logic pop,
    output rec_t head,
    output logic full,
    output logic empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0] wr_q;
    logic [AW:0] rd_q;
    rec_t        mem_q [DEPTH];
    logic        do_push;
    logic        do_pop;

    always_comb begin
        empty   = (wr_q == rd_q);
        full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
        do_pop  = pop && !empty;
        // A pop on the same edge frees the slot a full-FIFO push needs.
        do_push = push && (!full || do_pop);
        // Stale storage is never shown: the head reads as zero while empty.
        head    = empty ? '0 : mem_q[rd_q[AW-1:0]];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/pipeline_trace_emitter.sv
// Shadows a 5-stage pipeline (F/D/X/M/W) and emits one timestamped trace record
// per retiring instruction through a small FIFO, counting records lost to overflow.
module pipeline_trace_emitter
    import trace_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 16
) (
    input logic                     clk,
    input logic                     rst_n,
    pipeline_trace_emitter_if.slave bus
);

    slot_t              f_q, d_q, x_q, m_q, w_q;
    cyc_t               cyc_q;
    logic [DROP_W-1:0]  drop_q;

    rec_t               push_rec;
    rec_t               head;
    logic               full;
    logic               empty;
    logic               push;
    logic               pop;
    logic               drop;
    logic               unused_hi;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cyc_q <= '0;
            f_q   <= '0;
            d_q   <= '0;
            x_q   <= '0;
            m_q   <= '0;
            w_q   <= '0;
        end else begin
            cyc_q <= cyc_q + 1'b1;
            w_q   <= m_q;
            m_q   <= x_q;
            if (bus.flush) begin
                // The killed D slot moves on as a bubble; fetch is ignored.
                f_q.valid <= 1'b0;
                d_q.valid <= 1'b0;
                x_q       <= '0;
            end else if (bus.stall) begin
                x_q <= '0;
                if (d_q.valid) d_q.stall_cnt <= sat_inc_stall(d_q.stall_cnt);
            end else begin
                x_q <= d_q;
                d_q <= f_q;
                f_q <= '{valid:     bus.if_valid,
                         pc:        word_t'(bus.if_pc),
                         instr:     word_t'(bus.if_instr),
                         fetch_cyc: cyc_q,
                         stall_cnt: {STALL_W{1'b0}}};
            end
        end
    end

    always_comb begin
        push_rec = '{pc:         w_q.pc,
                     instr:      w_q.instr,
                     fetch_cyc:  w_q.fetch_cyc,
                     retire_cyc: cyc_q,
                     stall_cnt:  w_q.stall_cnt};
        push     = w_q.valid;
        pop      = !empty && bus.out_ready;
        drop     = push && full && !pop;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            drop_q <= '0;
        end else if (drop && (drop_q != DROP_CNT_MAX)) begin
            drop_q <= drop_q + 1'b1;
        end
    end

    trace_fifo #(
        .DEPTH (DEPTH),
        .rec_t (rec_t)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_rec),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty)
    );

    assign bus.out_valid      = !empty;
    assign bus.out_pc         = head.pc[W-1:0];
    assign bus.out_instr      = head.instr[W-1:0];
    assign bus.out_fetch_cyc  = head.fetch_cyc;
    assign bus.out_retire_cyc = head.retire_cyc;
    assign bus.out_stall_cnt  = head.stall_cnt;
    assign bus.drop_cnt       = drop_q;

    // Upper bits of the widened word fields are always zero.
    assign unused_hi = ^{head.pc, head.instr};

endmodule

// File: tb/tb_pipeline_trace_emitter.sv
// Self-checking bench for pipeline_trace_emitter: table-driven stream plus
// hand-written stall, overflow, full-FIFO and mid-stream reset sequences.
module tb_pipeline_trace_emitter;
    import trace_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned W     = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pipeline_trace_emitter_if #(.W(W)) bus ();

    pipeline_trace_emitter #(
        .DEPTH (DEPTH),
        .W     (W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [15:0] pc;
        logic [15:0] instr;
        logic [31:0] fcyc;
        logic [31:0] rcyc;
        logic [2:0]  scnt;
    } exp_t;

    typedef struct {
        logic        valid;
        logic [15:0] pc;
        logic [15:0] instr;
        logic        flush;
        logic        emit;
    } vec_t;

    exp_t        exp_q[$];
    vec_t        vecs[9];
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] cyc_m    = 0;

    // Reference cycle counter: the value the DUT samples at the next edge.
    always @(posedge clk) begin
        if (!rst_n) cyc_m <= 0;
        else        cyc_m <= cyc_m + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    // Compare the head if it is consumed on the coming edge, then take that edge.
    task automatic step();
        if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_record: got pc 0x%0h expected none", bus.out_pc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("rec_pc",     32'(bus.out_pc),     32'(e.pc));
                chk("rec_instr",  32'(bus.out_instr),  32'(e.instr));
                chk("rec_fetch",  bus.out_fetch_cyc,   e.fcyc);
                chk("rec_retire", bus.out_retire_cyc,  e.rcyc);
                chk("rec_stall",  32'(bus.out_stall_cnt), 32'(e.scnt));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.if_valid = 1'b0;
        bus.if_pc    = '0;
        bus.if_instr = '0;
    endtask

    // Present a fetch for the coming edge; queue its record when it should retire.
    task automatic fetch(input logic [15:0] pc, input logic [15:0] instr, input logic emit,
                         input int extra, input logic [2:0] scnt);
        exp_t e;
        bus.if_valid = 1'b1;
        bus.if_pc    = pc;
        bus.if_instr = instr;
        if (emit) begin
            e.pc    = pc;
            e.instr = instr;
            e.fcyc  = cyc_m;
            e.rcyc  = cyc_m + 32'd5 + 32'(extra);
            e.scnt  = scnt;
            exp_q.push_back(e);
        end
    endtask

    task automatic do_reset(input int n);
        rst_n     = 1'b0;
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        idle();
        repeat (n) begin
            @(posedge clk);
            #1;
        end
        exp_q.delete();
        rst_n = 1'b1;
    endtask

    task automatic drain(input int budget);
        idle();
        bus.out_ready = 1'b1;
        for (int i = 0; i < budget; i++) step();
        chk("drain_left", 32'(exp_q.size()), 32'd0);
        chk("drain_empty", 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        bus.stall     = 1'b0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        idle();

        vecs[0] = '{1'b1, 16'h0100, 16'h1111, 1'b0, 1'b1};
        vecs[1] = '{1'b1, 16'h0102, 16'h2222, 1'b0, 1'b1};
        vecs[2] = '{1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 16'h0104, 16'h3333, 1'b0, 1'b1};
        vecs[4] = '{1'b1, 16'h0020, 16'hB020, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 16'h0022, 16'hB022, 1'b0, 1'b0};
        vecs[6] = '{1'b1, 16'h0024, 16'hB024, 1'b1, 1'b0};
        vecs[7] = '{1'b1, 16'h0106, 16'h4444, 1'b0, 1'b1};
        vecs[8] = '{1'b1, 16'h0108, 16'h5555, 1'b0, 1'b1};

        // Reset state.
        do_reset(2);
        chk("rst_valid",  32'(bus.out_valid), 32'd0);
        chk("rst_pc",     32'(bus.out_pc), 32'd0);
        chk("rst_instr",  32'(bus.out_instr), 32'd0);
        chk("rst_fetch",  bus.out_fetch_cyc, 32'd0);
        chk("rst_retire", bus.out_retire_cyc, 32'd0);
        chk("rst_stall",  32'(bus.out_stall_cnt), 32'd0);
        chk("rst_drop",   32'(bus.drop_cnt), 32'd0);

        // Single instruction, five-edge latency, no same-cycle bypass.
        bus.out_ready = 1'b1;
        fetch(16'h0010, 16'hA123, 1'b1, 0, 3'd0);
        step();
        idle();
        repeat (4) step();
        chk("no_bypass", 32'(bus.out_valid), 32'd0);
        step();
        chk("valid_after_push", 32'(bus.out_valid), 32'd1);
        drain(4);

        // Table-driven stream with gaps and a flush.
        do_reset(1);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            bus.flush = vecs[i].flush;
            if (vecs[i].valid) fetch(vecs[i].pc, vecs[i].instr, vecs[i].emit, 0, 3'd0);
            else               idle();
            step();
        end
        bus.flush = 1'b0;
        drain(12);
        chk("flush_drop", 32'(bus.drop_cnt), 32'd0);

        // Three stall edges while the first instruction sits in D.
        do_reset(1);
        bus.out_ready = 1'b1;
        fetch(16'h0010, 16'hA123, 1'b1, 3, 3'd3);
        step();
        fetch(16'h0012, 16'hB000, 1'b1, 3, 3'd0);
        step();
        idle();
        bus.stall = 1'b1;
        repeat (3) step();
        bus.stall = 1'b0;
        drain(12);

        // Nine stall edges: stall count saturates at 7.
        do_reset(1);
        bus.out_ready = 1'b1;
        fetch(16'h0030, 16'hC000, 1'b1, 9, 3'd7);
        step();
        idle();
        step();
        bus.stall = 1'b1;
        repeat (9) step();
        bus.stall = 1'b0;
        drain(14);

        // Overflow: six back-to-back with no consumer, four kept, two dropped.
        do_reset(1);
        bus.out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            fetch(16'h0040 + 16'(2 * i), 16'hD000 + 16'(i), (i < 4), 0, 3'd0);
            step();
        end
        idle();
        repeat (6) step();
        chk("ovf_drop", 32'(bus.drop_cnt), 32'd2);
        chk("ovf_valid", 32'(bus.out_valid), 32'd1);
        chk("hold_pc_a", 32'(bus.out_pc), 32'h0040);
        step();
        step();
        chk("hold_pc_b", 32'(bus.out_pc), 32'h0040);
        drain(8);
        chk("ovf_drop_after", 32'(bus.drop_cnt), 32'd2);

        // Mid-stream reset with three records queued and two in flight.
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            fetch(16'h0060 + 16'(2 * i), 16'hF000 + 16'(i), 1'b0, 0, 3'd0);
            step();
        end
        idle();
        repeat (3) step();
        chk("pre_rst_valid", 32'(bus.out_valid), 32'd1);
        do_reset(1);
        chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_pc", 32'(bus.out_pc), 32'd0);
        chk("mid_rst_retire", bus.out_retire_cyc, 32'd0);
        chk("mid_rst_drop", 32'(bus.drop_cnt), 32'd0);
        bus.out_ready = 1'b1;
        fetch(16'h0050, 16'hE000, 1'b1, 0, 3'd0);
        step();
        drain(12);

        // Full FIFO: push and pop on the same edge, then a true overflow.
        do_reset(1);
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            fetch(16'h0070 + 16'(2 * i), 16'h7000 + 16'(i), 1'b1, 0, 3'd0);
            step();
        end
        idle();
        repeat (4) step();
        chk("full_valid", 32'(bus.out_valid), 32'd1);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        chk("pushpop_drop", 32'(bus.drop_cnt), 32'd0);
        chk("pushpop_head", 32'(bus.out_pc), 32'h0072);
        fetch(16'h0080, 16'h8000, 1'b0, 0, 3'd0);
        step();
        idle();
        repeat (6) step();
        chk("still_full_drop", 32'(bus.drop_cnt), 32'd1);
        drain(8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
